// File: rtl/alu_seq_pkg.sv
// Shared opcode, state and flag definitions for the handshaked ALU.
package alu_seq_pkg;

    localparam logic [1:0] U_RSV   = 2'b00;
    localparam logic [1:0] U_ARITH = 2'b01;
    localparam logic [1:0] U_LOGIC = 2'b10;
    localparam logic [1:0] U_MULTI = 2'b11;

    localparam logic [1:0] OP_ADD = 2'b00;
    localparam logic [1:0] OP_SUB = 2'b01;
    localparam logic [1:0] OP_INC = 2'b10;
    localparam logic [1:0] OP_DEC = 2'b11;

    localparam logic [1:0] OP_AND = 2'b00;
    localparam logic [1:0] OP_OR  = 2'b01;
    localparam logic [1:0] OP_XOR = 2'b10;
    localparam logic [1:0] OP_NOT = 2'b11;

    localparam logic [1:0] OP_MUL = 2'b00;
    localparam logic [1:0] OP_SLL = 2'b01;
    localparam logic [1:0] OP_SRL = 2'b10;
    localparam logic [1:0] OP_SRA = 2'b11;

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_BUSY = 2'b01,
        S_DONE = 2'b10
    } state_t;

    typedef struct packed {
        logic [1:0] unit;
        logic [1:0] op;
    } opcode_t;

endpackage

// File: rtl/alu_comb.sv
// Single-cycle arithmetic/logic datapath with carry and overflow generation.
module alu_comb
    import alu_seq_pkg::*;
#(
    parameter int unsigned W = 32
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  opcode_t      f,
    output logic [W-1:0] res_c,
    output logic         c_c,
    output logic         o_c
);

    logic [W-1:0] opb;
    logic         cin;
    logic [W:0]   sum;

    // Every arithmetic op is a + opb + cin; subtraction uses the inverted operand.
    always_comb begin
        opb = b;
        cin = 1'b0;
        case (f.op)
            OP_ADD: begin opb = b;          cin = 1'b0; end
            OP_SUB: begin opb = ~b;         cin = 1'b1; end
            OP_INC: begin opb = W'(1);      cin = 1'b0; end
            OP_DEC: begin opb = ~(W'(1));   cin = 1'b1; end
            default: ;
        endcase
        sum = {1'b0, a} + {1'b0, opb} + (W+1)'(cin);
    end

    always_comb begin
        res_c = '0;
        c_c   = 1'b0;
        o_c   = 1'b0;
        case (f.unit)
            U_ARITH: begin
                res_c = sum[W-1:0];
                c_c   = sum[W];
                o_c   = (a[W-1] == opb[W-1]) && (sum[W-1] != a[W-1]);
            end
            U_LOGIC: begin
                case (f.op)
                    OP_AND:  res_c = a & b;
                    OP_OR:   res_c = a | b;
                    OP_XOR:  res_c = a ^ b;
                    default: res_c = ~a;
                endcase
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/alu_seq.sv
// Handshaked ALU: single-cycle ops via alu_comb, iterative multiply and bit-serial shifts.
module alu_seq
    import alu_seq_pkg::*;
#(
    parameter int unsigned W      = 32,
    parameter bit          MUL_EN = 1'b1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] A,
    input  logic [W-1:0] B,
    input  logic [3:0]   f,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] S,
    output logic         sig_Z,
    output logic         sig_C,
    output logic         sig_O,
    output logic         sig_N
);

    localparam int unsigned AW = $clog2(W);
    localparam int unsigned CW = $clog2(W + 1);

    opcode_t          op_in;
    state_t           state_q, state_d;
    logic [CW-1:0]    cnt_q;
    logic [1:0]       op_q;
    logic [W-1:0]     mcand_q;
    logic [2*W-1:0]   prod_q;
    logic [AW-1:0]    amt;
    logic             is_mul, is_shift, go_busy;
    logic [W-1:0]     comb_res;
    logic             comb_c, comb_o;
    logic [W:0]       mul_sum;
    logic [2*W-1:0]   prod_step;
    logic             sh_out;
    logic             load;
    logic [W-1:0]     res_d;
    logic             c_d, o_d;

    assign op_in    = opcode_t'(f);
    assign amt      = B[AW-1:0];
    assign is_mul   = MUL_EN && (op_in.unit == U_MULTI) && (op_in.op == OP_MUL);
    assign is_shift = (op_in.unit == U_MULTI) && (op_in.op != OP_MUL);
    assign go_busy  = is_mul || (is_shift && (amt != '0));

    alu_comb #(.W(W)) u_comb (
        .a     (A),
        .b     (B),
        .f     (op_in),
        .res_c (comb_res),
        .c_c   (comb_c),
        .o_c   (comb_o)
    );

    // One iteration: shift-add on {hi,lo} for MUL, one-bit shift of lo otherwise.
    always_comb begin
        mul_sum   = {1'b0, prod_q[2*W-1:W]} + (prod_q[0] ? {1'b0, mcand_q} : '0);
        prod_step = prod_q;
        sh_out    = 1'b0;
        case (op_q)
            OP_MUL: prod_step = {mul_sum, prod_q[W-1:1]};
            OP_SLL: begin
                prod_step[W-1:0] = {prod_q[W-2:0], 1'b0};
                sh_out           = prod_q[W-1];
            end
            OP_SRL: begin
                prod_step[W-1:0] = {1'b0, prod_q[W-1:1]};
                sh_out           = prod_q[0];
            end
            default: begin
                prod_step[W-1:0] = {prod_q[W-1], prod_q[W-1:1]};
                sh_out           = prod_q[0];
            end
        endcase
    end

    // Result/flag selection for the cycle that enters DONE.
    always_comb begin
        load  = 1'b0;
        res_d = comb_res;
        c_d   = comb_c;
        o_d   = comb_o;
        if (state_q == S_IDLE && in_valid && !go_busy) begin
            load = 1'b1;
            if (is_shift) begin
                res_d = A;
                c_d   = 1'b0;
                o_d   = 1'b0;
            end
        end else if (state_q == S_BUSY && cnt_q == CW'(1)) begin
            load  = 1'b1;
            res_d = prod_step[W-1:0];
            if (op_q == OP_MUL) begin
                c_d = |prod_step[2*W-1:W];
                o_d = |prod_step[2*W-1:W];
            end else begin
                c_d = sh_out;
                o_d = 1'b0;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: if (in_valid) state_d = go_busy ? S_BUSY : S_DONE;
            S_BUSY: if (cnt_q == CW'(1)) state_d = S_DONE;
            S_DONE: if (out_ready) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
        end else begin
            state_q   <= state_d;
            out_valid <= (state_d == S_DONE);
            in_ready  <= (state_d == S_IDLE);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q   <= '0;
            op_q    <= '0;
            mcand_q <= '0;
            prod_q  <= '0;
            S       <= '0;
            sig_Z   <= 1'b0;
            sig_C   <= 1'b0;
            sig_O   <= 1'b0;
            sig_N   <= 1'b0;
        end else begin
            if (state_q == S_IDLE && in_valid) begin
                op_q    <= op_in.op;
                mcand_q <= A;
                prod_q  <= is_mul ? {W'(0), B} : {W'(0), A};
                cnt_q   <= is_mul ? CW'(W) : CW'(amt);
            end else if (state_q == S_BUSY) begin
                prod_q <= prod_step;
                cnt_q  <= cnt_q - CW'(1);
            end
            if (load) begin
                S     <= res_d;
                sig_Z <= (res_d == '0);
                sig_C <= c_d;
                sig_O <= o_d;
                sig_N <= res_d[W-1];
            end
        end
    end

endmodule

// File: tb/tb_alu_seq.sv
// Scoreboard bench for alu_seq: directed vectors, monitor compares S, flags and latency.
module tb_alu_seq;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [W-1:0] A = '0;
    logic [W-1:0] B = '0;
    logic [3:0]   f = '0;
    logic         out_valid;
    logic         out_ready = 1'b1;
    logic [W-1:0] S;
    logic         sig_Z, sig_C, sig_O, sig_N;

    always #5 clk = ~clk;

    alu_seq #(.W(W), .MUL_EN(1'b1)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .A(A), .B(B), .f(f), .out_valid(out_valid), .out_ready(out_ready),
        .S(S), .sig_Z(sig_Z), .sig_C(sig_C), .sig_O(sig_O), .sig_N(sig_N)
    );

    typedef struct {
        logic [31:0] s;
        logic [3:0]  fl;
        int          lat;
        int          acc;
        string       name;
    } exp_t;

    exp_t sb[$];
    int   cyc = 0;
    int   n_tests = 0;
    int   n_fail = 0;
    bit   seen = 1'b0;
    int   first_cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: pops one expectation per consumed result ({Z,C,O,N} flag order).
    always @(negedge clk) begin
        exp_t e;
        if (rst_n && out_valid) begin
            if (!seen) begin
                seen = 1'b1;
                first_cyc = cyc;
            end
            if (out_ready) begin
                if (sb.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL stale_result: got S=%0h with no expected entry", S);
                end else begin
                    e = sb.pop_front();
                    chk({e.name, " S"}, 64'(S), 64'(e.s));
                    chk({e.name, " flags"}, 64'({sig_Z, sig_C, sig_O, sig_N}), 64'(e.fl));
                    chk({e.name, " latency"}, 64'(first_cyc - e.acc + 1), 64'(e.lat));
                end
                seen = 1'b0;
            end
        end
    end

    task automatic send(input string name, input logic [3:0] fi, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] s, input logic [3:0] fl,
                        input int lat);
        exp_t e;
        int   k;
        k = 0;
        @(negedge clk);
        while (!in_ready && k < 300) begin
            @(negedge clk);
            k++;
        end
        if (!in_ready) begin
            chk({name, " in_ready_timeout"}, 64'(in_ready), 64'(1));
            return;
        end
        in_valid = 1'b1;
        f = fi;
        A = a;
        B = b;
        e.s = s;
        e.fl = fl;
        e.lat = lat;
        e.acc = cyc + 1;
        e.name = name;
        sb.push_back(e);
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int k;
        k = 0;
        while (sb.size() != 0 && k < 3000) begin
            @(negedge clk);
            k++;
        end
        if (sb.size() != 0) chk("drain_timeout", 64'(sb.size()), 64'(0));
        repeat (3) @(negedge clk);
    endtask

    initial begin
        repeat (2) @(negedge clk);
        chk("reset in_ready", 64'(in_ready), 64'(1));
        chk("reset out_valid", 64'(out_valid), 64'(0));
        chk("reset S", 64'(S), 64'(0));
        chk("reset flags", 64'({sig_Z, sig_C, sig_O, sig_N}), 64'(0));
        rst_n = 1'b1;

        send("add_ovf",  4'b0100, 32'h7FFF_FFFF, 32'h1,         32'h8000_0000, 4'b0011, 1);
        send("sub_eq",   4'b0101, 32'h5,         32'h5,         32'h0,         4'b1100, 1);
        send("dec_zero", 4'b0111, 32'h0,         32'h0,         32'hFFFF_FFFF, 4'b0001, 1);
        send("dec_min",  4'b0111, 32'h8000_0000, 32'h0,         32'h7FFF_FFFF, 4'b0110, 1);
        send("inc_wrap", 4'b0110, 32'hFFFF_FFFF, 32'h0,         32'h0,         4'b1100, 1);
        send("sub_brw",  4'b0101, 32'h0,         32'h1,         32'hFFFF_FFFF, 4'b0001, 1);
        send("add_wrap", 4'b0100, 32'hFFFF_FFFF, 32'h1,         32'h0,         4'b1100, 1);
        send("and",      4'b1000, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'hF000_F000, 4'b0001, 1);
        send("or_zero",  4'b1001, 32'h0,         32'h0,         32'h0,         4'b1000, 1);
        send("xor",      4'b1010, 32'hAAAA_AAAA, 32'h5555_5555, 32'hFFFF_FFFF, 4'b0001, 1);
        send("not",      4'b1011, 32'hFFFF_FFFF, 32'h0,         32'h0,         4'b1000, 1);
        send("reserved", 4'b0011, 32'h5,         32'h6,         32'h0,         4'b1000, 1);
        send("mul_hi",   4'b1100, 32'h0001_0000, 32'h0001_0000, 32'h0,         4'b1110, 33);
        send("mul_7x6",  4'b1100, 32'h7,         32'h6,         32'h2A,        4'b0000, 33);
        send("mul_max",  4'b1100, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h1,         4'b0110, 33);
        send("sra4",     4'b1111, 32'h8000_0000, 32'h4,         32'hF800_0000, 4'b0001, 5);
        send("sll1",     4'b1101, 32'h8000_0001, 32'h1,         32'h2,         4'b0100, 2);
        send("srl0",     4'b1110, 32'h1234_5678, 32'h0,         32'h1234_5678, 4'b0000, 1);
        send("srl_b33",  4'b1110, 32'h8000_0001, 32'd33,        32'h4000_0000, 4'b0100, 2);
        send("srl31",    4'b1110, 32'hC000_0000, 32'd31,        32'h1,         4'b0100, 32);
        drain();

        // Backpressure: result must hold while out_ready is low.
        out_ready = 1'b0;
        send("bp_add", 4'b0100, 32'h2, 32'h3, 32'h5, 4'b0000, 1);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            #1;
            chk("bp S hold", 64'(S), 64'(5));
            chk("bp flags hold", 64'({sig_Z, sig_C, sig_O, sig_N}), 64'(0));
            chk("bp out_valid hold", 64'(out_valid), 64'(1));
            chk("bp in_ready low", 64'(in_ready), 64'(0));
            in_valid = 1'b1;
            f = 4'b0100;
            A = 32'd100;
            B = 32'd100;
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        #1;
        chk("bp no pass-through", 64'(in_ready), 64'(0));
        @(negedge clk);
        #1;
        chk("bp out_valid drop", 64'(out_valid), 64'(0));
        chk("bp in_ready rise", 64'(in_ready), 64'(1));
        chk("bp ignored input", 64'(sb.size()), 64'(0));
        drain();

        // Reset in the middle of a multiply.
        send("rst_mul", 4'b1100, 32'h3, 32'h4, 32'hC, 4'b0000, 33);
        repeat (9) @(negedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        chk("abort S", 64'(S), 64'(0));
        chk("abort flags", 64'({sig_Z, sig_C, sig_O, sig_N}), 64'(0));
        chk("abort out_valid", 64'(out_valid), 64'(0));
        chk("abort in_ready", 64'(in_ready), 64'(1));
        sb.delete();
        seen = 1'b0;
        @(negedge clk);
        #1;
        rst_n = 1'b1;
        send("post_rst_add", 4'b0100, 32'h2, 32'h3, 32'h5, 4'b0000, 1);
        drain();
        repeat (40) @(negedge clk);
        chk("idle after drain", 64'(out_valid), 64'(0));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
